// File: rtl/dbuf_pkg.sv
// dbuf_tx_sched shared definitions.
// K characters, frame states and frame length helper.
package dbuf_pkg;

  localparam logic [7:0] K_START = 8'h5C;
  localparam logic [7:0] K_STOP  = 8'h3C;
  localparam logic [7:0] K_COMMA = 8'hBC;

  // start, address, stop and two checksum bytes
  localparam int FRAME_OVERHEAD = 5;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    DATA,
    STOP,
    CSUM_H,
    CSUM_L,
    GAP
  } dbuf_state_t;

  function automatic int frame_slots(input int seg_bytes);
    return seg_bytes + FRAME_OVERHEAD;
  endfunction

endpackage

// File: rtl/dbuf_tx_sched_rr_arbiter.sv
// Round-robin arbiter for the segment requesters.
// Pointer moves past a requester only once its frame completes.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  input  logic [$clog2(N)-1:0] served,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;

  // search from ptr upward; scanning down lets the nearest hit win
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'((int'(ptr) + k) % N);
      end
    end
  end

  // next search starts after the requester just served
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(served) == N - 1) ? '0 : served + IW'(1);
    end
  end

endmodule

// File: rtl/dbuf_tx_sched.sv
// Data-buffer transmit scheduler: round-robin segment framing
// onto the slot-interleaved data-buffer byte lane.
module dbuf_tx_sched
  import dbuf_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int SEG_BYTES = 16,
  parameter int MIN_GAP   = 4
) (
  input  logic                        tx_clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*8-1:0]           addr,
  input  logic [NREQ*SEG_BYTES*8-1:0] data,
  output logic [NREQ-1:0]             done,
  output logic                        busy,
  output logic [$clog2(NREQ)-1:0]     grant_id,
  output logic                        slot,
  output logic [7:0]                  dbuf_byte,
  output logic                        dbuf_isk
);

  localparam int IW = $clog2(NREQ);
  localparam int CMAX = (SEG_BYTES > MIN_GAP) ? SEG_BYTES : MIN_GAP;
  localparam int CW = $clog2(CMAX);

  dbuf_state_t state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [15:0]   csum, nxt_csum;
  logic [IW-1:0] nxt_gid;
  logic          nxt_busy;
  logic [7:0]    byte_sel, abyte, dbyte;
  logic          isk_sel, last, fin;
  logic          gnt_valid;
  logic [IW-1:0] gnt_idx;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk       (tx_clk),
    .rst       (rst),
    .req       (req),
    .advance   (fin),
    .served    (grant_id),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // live byte pick for the granted requester; byte 0 is the MSB
  always_comb begin
    abyte = addr[int'(grant_id)*8 +: 8];
    dbyte = data[(int'(grant_id)*SEG_BYTES + SEG_BYTES - 1
                  - int'(cnt))*8 +: 8];
  end

  // next-state, checksum and lane byte selection
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_csum  = csum;
    nxt_gid   = grant_id;
    nxt_busy  = busy;
    byte_sel  = 8'h00;
    isk_sel   = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt_valid) begin
          nxt_gid   = gnt_idx;
          nxt_busy  = 1'b1;
          nxt_state = START;
        end
      end
      START: begin
        byte_sel  = K_START;
        isk_sel   = 1'b1;
        nxt_csum  = '0;
        nxt_state = ADDR;
      end
      ADDR: begin
        byte_sel  = abyte;
        nxt_csum  = csum + 16'(abyte);
        nxt_cnt   = '0;
        nxt_state = DATA;
      end
      DATA: begin
        byte_sel = dbyte;
        nxt_csum = csum + 16'(dbyte);
        if (cnt == CW'(SEG_BYTES - 1)) begin
          nxt_state = STOP;
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end
      STOP: begin
        byte_sel  = K_STOP;
        isk_sel   = 1'b1;
        nxt_state = CSUM_H;
      end
      CSUM_H: begin
        byte_sel  = ~csum[15:8];
        nxt_state = CSUM_L;
      end
      CSUM_L: begin
        byte_sel  = ~csum[7:0];
        last      = 1'b1;
        nxt_cnt   = '0;
        nxt_state = GAP;
      end
      GAP: begin
        if (cnt == CW'(MIN_GAP - 1)) begin
          nxt_busy  = 1'b0;
          nxt_state = IDLE;
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // completion only counts on a live slot of the last byte
  always_comb begin
    fin  = last & slot & ena;
    done = '0;
    if (fin) done[grant_id] = 1'b1;
    dbuf_byte = slot ? byte_sel : 8'h00;
    dbuf_isk  = slot & isk_sel;
  end

  // slot phase and frame state; ena low aborts to idle
  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      csum     <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      slot     <= 1'b0;
    end else if (!ena) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      slot  <= 1'b0;
    end else begin
      slot <= ~slot;
      if (slot) begin
        state    <= nxt_state;
        cnt      <= nxt_cnt;
        csum     <= nxt_csum;
        grant_id <= nxt_gid;
        busy     <= nxt_busy;
      end
    end
  end

endmodule

// File: tb/tb_dbuf_tx_sched.sv
// Scoreboard bench for dbuf_tx_sched: frames predicted from
// round-robin rules and the checksum definition.
module tb_dbuf_tx_sched;
  import dbuf_pkg::*;

  localparam int NREQ = 4;
  localparam int SEG = 16;
  localparam int MIN_GAP = 4;
  localparam int FL = frame_slots(SEG);
  localparam int FW = FL * 8;

  logic clk = 1'b0;
  logic rst;
  logic ena;
  logic [NREQ-1:0] req;
  logic [NREQ*8-1:0] addr;
  logic [NREQ*SEG*8-1:0] data;
  logic [NREQ-1:0] done;
  logic busy;
  logic [1:0] grant_id;
  logic slot;
  logic [7:0] dbuf_byte;
  logic dbuf_isk;

  always #5 clk = ~clk;

  dbuf_tx_sched #(
    .NREQ(NREQ), .SEG_BYTES(SEG), .MIN_GAP(MIN_GAP)
  ) dut (
    .tx_clk    (clk),
    .rst       (rst),
    .ena       (ena),
    .req       (req),
    .addr      (addr),
    .data      (data),
    .done      (done),
    .busy      (busy),
    .grant_id  (grant_id),
    .slot      (slot),
    .dbuf_byte (dbuf_byte),
    .dbuf_isk  (dbuf_isk)
  );

  int n_chk = 0;
  int n_fail = 0;
  int exp_id_q[$];
  logic [FW-1:0] exp_q[$];
  int phase_no = 0;
  int rr_ptr = 0;
  int left[NREQ];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_byte(input int id, input int b,
                          input logic [7:0] v);
    data[(id*SEG + SEG-1-b)*8 +: 8] = v;
  endtask

  function automatic logic [7:0] get_byte(input int id, input int b);
    return data[(id*SEG + SEG-1-b)*8 +: 8];
  endfunction

  task automatic rand_payload();
    for (int i = 0; i < NREQ; i++) begin
      addr[i*8 +: 8] = 8'($urandom);
      for (int b = 0; b < SEG; b++) set_byte(i, b, 8'($urandom));
    end
  endtask

  function automatic logic [FW-1:0] build(input int id);
    logic [FW-1:0] f;
    logic [15:0] s;
    logic [7:0] a;
    logic [7:0] b;
    f = '0;
    a = addr[id*8 +: 8];
    s = 16'(a);
    f[FW-1 -: 8] = K_START;
    f[FW-9 -: 8] = a;
    for (int j = 0; j < SEG; j++) begin
      b = get_byte(id, j);
      s = s + 16'(b);
      f[FW-1-8*(j+2) -: 8] = b;
    end
    s = 16'hFFFF - s;
    f[FW-1-8*(SEG+2) -: 8] = K_STOP;
    f[FW-1-8*(SEG+3) -: 8] = s[15:8];
    f[FW-1-8*(SEG+4) -: 8] = s[7:0];
    return f;
  endfunction

  task automatic start_phase(input logic [NREQ-1:0] mask,
                             input int reps);
    int c[NREQ];
    int remaining;
    bit found;
    int id;
    phase_no++;
    remaining = 0;
    for (int i = 0; i < NREQ; i++) begin
      left[i] = mask[i] ? reps : 0;
      c[i] = left[i];
      remaining += c[i];
    end
    while (remaining > 0) begin
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        id = (rr_ptr + k) % NREQ;
        if (!found && c[id] > 0) begin
          found = 1;
          exp_id_q.push_back(id);
          exp_q.push_back(build(id));
          c[id]--;
          remaining--;
          rr_ptr = (id + 1) % NREQ;
        end
      end
    end
    req = mask;
  endtask

  task automatic finish_phase();
    int t;
    t = 0;
    while (req != '0 && t < 4000) begin
      @(negedge clk);
      t++;
      for (int i = 0; i < NREQ; i++) begin
        if (done[i] && req[i]) begin
          left[i]--;
          if (left[i] <= 0) req[i] = 1'b0;
        end
      end
    end
    chk("phase_timeout", 64'(req), 64'd0);
    if (req != '0) begin
      req = '0;
      exp_q.delete();
      exp_id_q.delete();
    end
  endtask

  task automatic wait_start();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(slot && dbuf_isk && dbuf_byte == K_START) && t < 500);
    chk("start_seen", 64'(t < 500), 64'd1);
  endtask

  task automatic wait_slots(input int n);
    int s;
    s = 0;
    while (s < n) begin
      @(negedge clk);
      if (slot) s++;
    end
  endtask

  task automatic monitor();
    logic [FW-1:0] cur;
    logic [FW-1:0] e;
    logic [FL-1:0] kp;
    logic [FL-1:0] ek;
    int nb;
    bit inf;
    int zeros;
    int end_phase;
    int id;
    nb = 0;
    inf = 0;
    zeros = 0;
    end_phase = -1;
    ek = '0;
    ek[FL-1] = 1'b1;
    ek[FL-1-(SEG+2)] = 1'b1;
    forever begin
      @(negedge clk);
      if (rst || !ena) begin
        inf = 0;
        nb = 0;
        if (rst) end_phase = -1;
      end else if (!slot) begin
        chk("lane_off", {done, dbuf_isk, dbuf_byte}, 64'd0);
      end else if (!inf) begin
        if (dbuf_isk && dbuf_byte == K_START) begin
          if (end_phase == phase_no)
            chk("gap_slots", 64'(zeros), 64'(MIN_GAP + 1));
          inf = 1;
          nb = 1;
          cur = '0;
          cur[FW-1 -: 8] = K_START;
          kp = '0;
          kp[FL-1] = 1'b1;
        end else begin
          chk("idle_lane", {done, dbuf_isk, dbuf_byte}, 64'd0);
          zeros++;
        end
      end else begin
        cur[FW-1-8*nb -: 8] = dbuf_byte;
        kp[FL-1-nb] = dbuf_isk;
        nb++;
        if (nb == FL) begin
          n_chk++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL frame: got unexpected frame %h", cur);
          end else begin
            id = exp_id_q.pop_front();
            e = exp_q.pop_front();
            if (cur !== e) begin
              n_fail++;
              $display("FAIL frame: got %h expected %h (req %0d)",
                       cur, e, id);
            end
            chk("frame_isk", 64'(kp), 64'(ek));
            chk("done_last", 64'(done), 64'(1) << id);
          end
          inf = 0;
          zeros = 0;
          end_phase = phase_no;
        end else begin
          chk("done_mid", 64'(done), 64'd0);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b0;
    req = '0;
    addr = '0;
    data = '0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);
    chk("rst_slot", 64'(slot), 64'd0);
    chk("rst_byte", {dbuf_isk, dbuf_byte}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    ena = 1'b1;
    #1 chk("slot_first", 64'(slot), 64'd0);
    @(negedge clk);
    chk("slot_second", 64'(slot), 64'd1);
    @(negedge clk);
    chk("slot_third", 64'(slot), 64'd0);

    rand_payload();
    addr = {8'h13, 8'h12, 8'h11, 8'h10};
    start_phase(4'hF, 1);
    finish_phase();

    data = '0;
    addr[7:0] = 8'hFF;
    set_byte(0, 1, 8'h08);
    set_byte(0, 7, 8'h07);
    set_byte(0, 15, 8'h07);
    start_phase(4'b0001, 1);
    finish_phase();

    addr[15:8] = 8'hFF;
    for (int b = 0; b < SEG; b++) set_byte(1, b, 8'hFF);
    start_phase(4'b0010, 1);
    finish_phase();

    rand_payload();
    start_phase(4'b0010, 1);
    wait_start();
    wait_slots(7);
    ena = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_slot", 64'(slot), 64'd0);
    chk("abort_lane", {done, dbuf_isk, dbuf_byte}, 64'd0);
    ena = 1'b1;
    finish_phase();

    rand_payload();
    start_phase(4'b0100, 3);
    finish_phase();

    for (int p = 0; p < 6; p++) begin
      rand_payload();
      start_phase(4'($urandom_range(1, 15)), 1);
      finish_phase();
    end

    rand_payload();
    start_phase(4'b1000, 1);
    wait_start();
    wait_slots(3);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_slot", 64'(slot), 64'd0);
    chk("arst_gid", 64'(grant_id), 64'd0);
    chk("arst_lane", {done, dbuf_isk, dbuf_byte}, 64'd0);
    req = '0;
    exp_q.delete();
    exp_id_q.delete();
    rr_ptr = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rand_payload();
    start_phase(4'b1001, 1);
    finish_phase();

    repeat (30) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
